// File: rtl/mult8_seq_ctrl_if.sv
// Handshake bundle for the sequential 8x8 multiplier.
// master = requester/consumer side, slave = the multiplier block.
interface mult8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier built from one 4x4 array multiplier.
// Four MUL cycles each add one shifted nibble product into an accumulator;
// the result is then held in DONE until the consumer takes it.
module mult8_seq_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    mult8_seq_ctrl_if.slave        bus,
    output logic                   busy,
    output logic [7:0]             ops_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_step;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [15:0] r_product;
    logic        r_out_valid;
    logic [7:0]  r_ops_cnt;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_out_hs;
    logic [3:0]  w_mul_x;
    logic [3:0]  w_mul_y;
    logic [7:0]  w_pp;
    logic [15:0] w_pp_shift;
    logic [15:0] w_acc_sum;

    // Ready only in IDLE and never while reset is asserted.
    assign w_in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_hs   = (r_state == S_DONE) && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;
    assign busy          = (r_state != S_IDLE);
    assign ops_cnt       = r_ops_cnt;

    // Select the nibble pair for the current step.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        w_mul_x = r_a[3:0];
        w_mul_y = r_b[3:0];
        case (r_step)
            2'd0: begin w_mul_x = r_a[3:0]; w_mul_y = r_b[3:0]; end
            2'd1: begin w_mul_x = r_a[7:4]; w_mul_y = r_b[3:0]; end
            2'd2: begin w_mul_x = r_a[3:0]; w_mul_y = r_b[7:4]; end
            2'd3: begin w_mul_x = r_a[7:4]; w_mul_y = r_b[7:4]; end
            default: ;
        endcase
    end

    // 4x4 array multiplier: one AND-row per multiplier bit, summed with its weight.
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_mul_y[i]) begin
                w_pp = w_pp + (8'(w_mul_x) << i);
            end
        end
    end

    // Weight the partial product by the nibble positions of this step.
    always_comb begin
        w_pp_shift = {8'h00, w_pp};
        case (r_step)
            2'd0:       w_pp_shift = {8'h00, w_pp};
            2'd1, 2'd2: w_pp_shift = {4'h0, w_pp, 4'h0};
            2'd3:       w_pp_shift = {w_pp, 8'h00};
            default: ;
        endcase
    end

    assign w_acc_sum = r_acc + w_pp_shift;

    // Next-state logic for IDLE -> MUL -> DONE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept)        w_state_nxt = S_MUL;
            S_MUL:  if (r_step == 2'd3)  w_state_nxt = S_DONE;
            S_DONE: if (bus.out_ready)   w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, accumulation, result register and handshake counter.
    always_ff @(posedge clk) begin
        // NOTE: every datapath register is reset, so an abandoned operation leaves no stale operands or product.
        if (rst) begin
            r_step      <= 2'd0;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_acc       <= 16'h0000;
            r_product   <= 16'h0000;
            r_out_valid <= 1'b0;
            r_ops_cnt   <= 8'h00;
        end else begin
            if (w_accept) begin
                r_a    <= bus.a;
                r_b    <= bus.b;
                r_acc  <= 16'h0000;
                r_step <= 2'd0;
            end else if (r_state == S_MUL) begin
                r_acc  <= w_acc_sum;
                r_step <= r_step + 2'd1;
                if (r_step == 2'd3) begin
                    r_product   <= w_acc_sum;
                    r_out_valid <= 1'b1;
                end
            end
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
                r_ops_cnt   <= r_ops_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Scoreboard bench for mult8_seq_ctrl: the stimulus pushes expected products,
// a negedge monitor pops them on each output handshake and also checks
// latency, hold stability, issue spacing and the handshake counter.
module tb_mult8_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] ops_cnt;

    mult8_seq_ctrl_if u_if ();

    mult8_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (u_if),
        .busy    (busy),
        .ops_cnt (ops_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit          prev_ov   = 1'b0;
    bit          pend_acc  = 1'b0;
    bit          have_last = 1'b0;
    bit          ops_pend  = 1'b0;
    int          acc_cyc   = 0;
    int          last_acc  = 0;
    logic [15:0] held      = '0;
    logic [7:0]  exp_ops   = '0;

    always @(negedge clk) begin
        if (ops_pend) begin
            check("ops_cnt_after_handshake", ops_cnt, exp_ops);
            ops_pend = 1'b0;
        end
        if (rst) begin
            pend_acc  = 1'b0;
            have_last = 1'b0;
            exp_ops   = '0;
            prev_ov   = 1'b0;
        end else begin
            if (u_if.out_valid && !prev_ov) begin
                check("out_valid_has_accept", pend_acc, 1);
                if (pend_acc) check("latency_edges", cyc - acc_cyc, 4);
                pend_acc = 1'b0;
                held     = u_if.product;
            end else if (u_if.out_valid) begin
                check("product_stable", u_if.product, held);
            end
            if (u_if.out_valid && u_if.out_ready) begin
                check("queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("product", u_if.product, exp_q.pop_front());
                exp_ops  = exp_ops + 8'd1;
                ops_pend = 1'b1;
            end
            if (u_if.in_valid && u_if.in_ready) begin
                if (have_last) check("issue_interval_ge6", (cyc + 1 - last_acc) >= 6, 1);
                last_acc  = cyc + 1;
                acc_cyc   = cyc + 1;
                have_last = 1'b1;
                pend_acc  = 1'b1;
            end
            prev_ov = u_if.out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!u_if.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("wait_in_ready", u_if.in_ready, 1);
    endtask

    // Present operands for one accept edge; returns one step after the accept edge.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input bit expect_out);
        wait_ready();
        u_if.in_valid = 1'b1;
        u_if.a        = x;
        u_if.b        = y;
        if (expect_out) exp_q.push_back({8'h00, x} * {8'h00, y});
        tick();
        u_if.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        // Reset held two edges with a pending request.
        rst           = 1'b1;
        u_if.in_valid = 1'b1;
        u_if.a        = 8'h55;
        u_if.b        = 8'h55;
        u_if.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  u_if.in_ready,  0);
        check("rst_out_valid", u_if.out_valid, 0);
        check("rst_product",   u_if.product,   16'h0000);
        check("rst_ops_cnt",   ops_cnt,        0);
        check("rst_busy",      busy,           0);
        rst           = 1'b0;
        u_if.in_valid = 1'b0;
        #1;
        check("idle_in_ready", u_if.in_ready, 1);

        // 0xFF * 0xFF with consumer always ready.
        u_if.out_ready = 1'b1;
        issue(8'hFF, 8'hFF, 1'b1);
        check("mul_busy",     busy,          1);
        check("mul_in_ready", u_if.in_ready, 0);
        repeat (3) tick();
        check("ff_not_yet_valid", u_if.out_valid, 0);
        tick();
        check("ff_out_valid", u_if.out_valid, 1);
        check("ff_product",   u_if.product,   16'hFE01);
        tick();
        check("ff_ops_cnt",   ops_cnt,        1);
        check("ff_in_ready",  u_if.in_ready,  1);
        check("ff_out_valid_cleared", u_if.out_valid, 0);

        // 0x12 * 0x34 with back-pressure and a competing request.
        u_if.out_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b1);
        u_if.in_valid = 1'b1;
        u_if.a        = 8'h99;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", u_if.out_valid, 1);
            check("hold_product",   u_if.product,   16'h03A8);
            check("hold_in_ready",  u_if.in_ready,  0);
            check("hold_ops_cnt",   ops_cnt,        1);
            tick();
        end
        u_if.out_ready = 1'b1;
        u_if.in_valid  = 1'b0;
        tick();
        check("release_ops_cnt",   ops_cnt,        2);
        check("release_out_valid", u_if.out_valid, 0);
        check("release_product_kept", u_if.product, 16'h03A8);

        // Nibble-boundary operands, then a zero operand.
        issue(8'h0F, 8'hF0, 1'b1);
        repeat (4) tick();
        check("0f_f0_product", u_if.product, 16'h0E10);
        issue(8'h00, 8'hAB, 1'b1);
        repeat (4) tick();
        check("zero_out_valid", u_if.out_valid, 1);
        check("zero_product",   u_if.product,   16'h0000);
        wait_ready();
        check("ops_cnt_4", ops_cnt, 4);

        // Reset pulse after the step1 edge abandons the operation.
        issue(8'h77, 8'h88, 1'b0);
        tick();
        tick();
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_busy",      busy,           0);
        check("abort_in_ready",  u_if.in_ready,  1);
        check("abort_out_valid", u_if.out_valid, 0);
        check("abort_ops_cnt",   ops_cnt,        0);
        repeat (6) tick();
        check("abort_no_valid_later", u_if.out_valid, 0);
        issue(8'h03, 8'h05, 1'b1);
        repeat (4) tick();
        check("after_abort_product", u_if.product, 16'h000F);
        wait_ready();
        check("after_abort_ops_cnt", ops_cnt, 1);

        // 256 back-to-back random transactions from a clean counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue(ra, rb, 1'b1);
        end
        wait_ready();
        check("ops_cnt_wrap", ops_cnt, 0);
        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult8_seq_ctrl.md
MULT8_SEQ_CTRL -- requirements
Module: mult8_seq_ctrl

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  requester has operands on a/b.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  8  unsigned multiplicand.
REQ-007 b  input  8  unsigned multiplier.
REQ-008 out_valid  output  1  product is valid.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 product  output  16  unsigned a*b.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 ops_cnt  output  8  count of completed output handshakes.

Function
REQ-013 Datapath: exactly one 4x4 unsigned combinational array multiplier instance, reused once per MUL cycle; no 8x8 multiplier shall be inferred.
REQ-014 FSM states: IDLE, MUL, DONE; 2-bit step counter used in MUL only.
REQ-015 in_ready = (state==IDLE) and not rst; combinational from state.
REQ-016 Accept: the edge where in_valid & in_ready; latch a, b into operand registers, clear accumulator, step=0, go to MUL.
REQ-017 Operand registers load only on accept; a/b changes at any other time have no effect.
REQ-018 MUL step order and shift: step0 a[3:0]*b[3:0] <<0; step1 a[7:4]*b[3:0] <<4; step2 a[3:0]*b[7:4] <<4; step3 a[7:4]*b[7:4] <<8.
REQ-019 Each MUL edge adds the shifted 8-bit partial product into a 16-bit accumulator; the sum cannot exceed 0xFE01, so no overflow handling is required.
REQ-020 On the step3 edge: state goes to DONE, product is loaded with the final sum, and out_valid goes to 1.
REQ-021 Latency: accept at edge E0, accumulation at E1..E4, out_valid high in the cycle after E4.
REQ-022 DONE: out_valid stays 1 and product stays stable until the edge where out_valid & out_ready.
- On that edge: go to IDLE, clear out_valid, increment ops_cnt.
- product keeps its last value after the handshake.
REQ-023 in_valid asserted during MUL or DONE is ignored and produces no accept.
- A new accept is possible no earlier than the edge after the output handshake.
- Minimum issue interval: 6 cycles.
REQ-024 out_ready is ignored outside DONE.
REQ-025 ops_cnt wraps 255 -> 0 with no flag.
REQ-026 busy = 1 in MUL and DONE, 0 in IDLE.

Reset
REQ-027 rst has priority over all other inputs, including an accept or output handshake on the same edge.
REQ-028 On any edge with rst=1:
- state=IDLE, step=0;
- accumulator=0, product=0, operand registers=0;
- out_valid=0, ops_cnt=0.
REQ-029 While rst=1: in_ready=0; busy reflects the state after the first reset edge.
REQ-030 Reset during MUL or DONE abandons the operation; no out_valid pulse and no ops_cnt increment result from it.

Verification
REQ-031 Reset held for 2 edges with in_valid=1, a=0x55, b=0x55 -> no accept; in_ready=0, out_valid=0, product=0x0000, ops_cnt=0, busy=0.
REQ-032 a=0xFF, b=0xFF accepted, out_ready=1 -> out_valid rises after the 4th post-accept edge with product=0xFE01; ops_cnt=1; in_ready=1 one cycle later.
REQ-033 a=0x12, b=0x34, out_ready=0 for 10 cycles, in_valid=1 with a=0x99 throughout -> product=0x03A8 held stable, in_ready=0, no second accept; ops_cnt increments only when out_ready rises.
REQ-034 a=0x0F, b=0xF0 -> product=0x0E10; then a=0x00, b=0xAB -> product=0x0000 with the same 4-edge latency.
REQ-035 rst pulsed for 1 edge after the step1 edge of an operation -> IDLE next cycle, out_valid never asserts, ops_cnt=0, next operation a=0x03, b=0x05 yields 0x000F.
REQ-036 256 back-to-back transactions with random operands checked against a*b -> ops_cnt reads 0 after the 256th handshake; issue interval is never below 6 cycles.
